// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR result path.
//   float_class_e : 2-bit class tag carried alongside each single-precision word
//   fir_result_t  : 34-bit FIFO entry {class, word}
//   classify_f32  : class of an IEEE-754 single-precision word (sign ignored)
package fir_pkg;

    typedef enum logic [1:0] {
        FC_NORMAL = 2'b00,
        FC_ZERO   = 2'b01,
        FC_INF    = 2'b10,
        FC_NAN    = 2'b11
    } float_class_e;

    localparam logic [7:0] FP_EXP_MAX = 8'hFF;

    typedef struct packed {
        float_class_e cls;
        logic [31:0]  data;
    } fir_result_t;

    // Denormals are reported as zero: only the exponent field decides zero-ness.
    function automatic float_class_e classify_f32(input logic [31:0] word);
        logic [7:0]   exp_f;
        logic [22:0]  man_f;
        float_class_e cls;
        exp_f = word[30:23];
        man_f = word[22:0];
        if (exp_f == 8'h00) begin
            cls = FC_ZERO;
        end else if (exp_f == FP_EXP_MAX) begin
            cls = (man_f == 23'd0) ? FC_INF : FC_NAN;
        end else begin
            cls = FC_NORMAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Single-clock show-ahead FIFO.
//   clk, rst (async, active-low), clr (sync clear)
//   push/wdata : write side; a push into a full FIFO is accepted only if a pop happens too
//   pop        : ignored while empty
//   rdata      : head entry, valid whenever empty=0
//   full/empty/level : occupancy, derived from pointers carrying an extra wrap bit
module fir_sync_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = LW'(wr_ptr_q - rd_ptr_q);
    assign rdata = mem[rd_ptr_q[AW-1:0]];

    assign do_pop  = pop && !empty;
    // A pop on a full FIFO frees the slot being written this cycle.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/fir_result_collector.sv
// Downstream stage of the FIR filter: classifies each result word, buffers it for a
// valid/accept consumer and tracks the run against the expected sample count.
//   clk, rst (async, active-low), clr (sync clear, same effect as reset)
//   in_data/in_ready   : FIR result and its one-cycle ready pulse (no backpressure)
//   out_data/out_class : head of buffer and its class (zero while empty)
//   out_valid/out_accept : consumer handshake
//   rx_count : results seen, saturating at N_SAMPLES+1
//   level    : buffer occupancy
//   done     : exactly N_SAMPLES received and all drained
//   overflow : sticky, a result was dropped on a full buffer
//   extra_err: sticky, a result arrived after N_SAMPLES were counted
module fir_result_collector
    import fir_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned N_SAMPLES = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic [31:0]                    in_data,
    input  logic                           in_ready,
    output logic [31:0]                    out_data,
    output logic [1:0]                     out_class,
    output logic                           out_valid,
    input  logic                           out_accept,
    output logic [$clog2(N_SAMPLES+2)-1:0] rx_count,
    output logic [$clog2(DEPTH+1)-1:0]     level,
    output logic                           done,
    output logic                           overflow,
    output logic                           extra_err
);

    localparam int unsigned CW = $clog2(N_SAMPLES + 2);
    localparam logic [CW-1:0] CntExp = CW'(N_SAMPLES);
    localparam logic [CW-1:0] CntSat = CW'(N_SAMPLES + 1);

    fir_result_t       in_entry, head;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     rx_count_q, rx_count_d;
    logic              overflow_q, overflow_d;
    logic              extra_err_q, extra_err_d;

    assign in_entry.cls  = classify_f32(in_data);
    assign in_entry.data = in_data;

    fir_sync_fifo #(
        .WIDTH ($bits(fir_result_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (in_ready),
        .wdata (in_entry),
        .pop   (out_accept),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_comb begin
        rx_count_d  = rx_count_q;
        overflow_d  = overflow_q;
        extra_err_d = extra_err_q;
        if (clr) begin
            rx_count_d  = '0;
            overflow_d  = 1'b0;
            extra_err_d = 1'b0;
        end else if (in_ready) begin
            if (rx_count_q != CntSat) rx_count_d = rx_count_q + 1'b1;
            if (rx_count_q >= CntExp) extra_err_d = 1'b1;
            // Full implies non-empty, so out_accept alone decides whether a slot frees up.
            if (fifo_full && !out_accept) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_count_q  <= '0;
            overflow_q  <= 1'b0;
            extra_err_q <= 1'b0;
        end else begin
            rx_count_q  <= rx_count_d;
            overflow_q  <= overflow_d;
            extra_err_q <= extra_err_d;
        end
    end

    // Head is masked while empty so stale storage never leaks to the consumer.
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? 32'd0 : head.data;
    assign out_class = fifo_empty ? 2'b00 : head.cls;
    assign rx_count  = rx_count_q;
    assign done      = (rx_count_q == CntExp) && fifo_empty;
    assign overflow  = overflow_q;
    assign extra_err = extra_err_q;

endmodule

// File: tb/tb_fir_result_collector.sv
module tb_fir_result_collector;

    localparam int DEPTH = 16;
    localparam int N     = 10;
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int CW    = $clog2(N + 2);
    localparam int VW    = 1 + 32 + 2 + LW + CW + 3;

    logic          clk = 1'b0;
    logic          rst, clr;
    logic [31:0]   in_data;
    logic          in_ready, out_accept;
    logic [31:0]   out_data;
    logic [1:0]    out_class;
    logic          out_valid, done, overflow, extra_err;
    logic [CW-1:0] rx_count;
    logic [LW-1:0] level;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of {class, word} plus counters and flags.
    logic [33:0] m_q[$];
    int          m_cnt;
    logic        m_ovf, m_extra;

    logic [VW-1:0] dut_vec;
    assign dut_vec = {out_valid, out_data, out_class, level, rx_count, done, overflow, extra_err};

    always #5 clk = ~clk;

    fir_result_collector #(
        .DEPTH     (DEPTH),
        .N_SAMPLES (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_class  (out_class),
        .out_valid  (out_valid),
        .out_accept (out_accept),
        .rx_count   (rx_count),
        .level      (level),
        .done       (done),
        .overflow   (overflow),
        .extra_err  (extra_err)
    );

    function automatic logic [1:0] ref_class(input logic [31:0] w);
        int unsigned e, m;
        e = (w >> 23) % 256;
        m = w % (1 << 23);
        if (e == 0) return 2'b01;
        if (e == 255) return (m == 0) ? 2'b10 : 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [VW-1:0] model_vec();
        logic [33:0] h;
        h = (m_q.size() != 0) ? m_q[0] : 34'd0;
        return {(m_q.size() != 0), h[31:0], h[33:32], LW'(m_q.size()), CW'(m_cnt),
                ((m_cnt == N) && (m_q.size() == 0)), m_ovf, m_extra};
    endfunction

    function automatic void model_clear();
        m_q.delete();
        m_cnt   = 0;
        m_ovf   = 1'b0;
        m_extra = 1'b0;
    endfunction

    function automatic void model_step(input logic rdy, input logic [31:0] d, input logic acc,
                                       input logic c);
        bit was_full, popped;
        if (c) begin
            model_clear();
            return;
        end
        was_full = (m_q.size() >= DEPTH);
        popped   = (m_q.size() > 0) && acc;
        if (popped) void'(m_q.pop_front());
        if (rdy) begin
            if (!was_full || popped) m_q.push_back({ref_class(d), d});
            else m_ovf = 1'b1;
            if (m_cnt >= N) m_extra = 1'b1;
            if (m_cnt < N + 1) m_cnt++;
        end
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 4))
            0: w[30:23] = 8'h00;
            1: begin w[30:23] = 8'hFF; w[22:0] = '0; end
            2: begin w[30:23] = 8'hFF; w[22:0] = 23'h1 | 23'($urandom); end
            default: ;
        endcase
        return w;
    endfunction

    task automatic cycle(input logic rdy, input logic [31:0] d, input logic acc);
        in_ready   = rdy;
        in_data    = d;
        out_accept = acc;
        @(posedge clk);
        model_step(rdy, d, acc, clr);
        #1;
        in_ready   = 1'b0;
        out_accept = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; clr = 1'b0; in_ready = 1'b0; in_data = '0; out_accept = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (dut_vec !== {VW{1'b0}}) begin
            bad++; $display("FAIL reset_state: got %h want %h", dut_vec, {VW{1'b0}});
        end
        rst = 1'b1;
        cycle(1'b0, 32'd0, 1'b1);
        total++;
        if (dut_vec !== model_vec()) begin
            bad++; $display("FAIL reset_release: got %h want %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_spaced();
        logic [31:0] words [10] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                    32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                                    32'h41100000, 32'h41200000};
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, words[i], 1'b1);
            total++;
            if ({out_valid, out_data, out_class} !== {1'b1, words[i], 2'b00}) begin
                bad++; $display("FAIL spaced_word%0d: got %b/%h/%b want 1/%h/00",
                                i, out_valid, out_data, out_class, words[i]);
            end
            cycle(1'b0, 32'd0, 1'b1);
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL spaced_pop%0d: got %h want %h", i, dut_vec, model_vec());
            end
        end
        total++;
        if ({rx_count, done, overflow, extra_err} !== {CW'(10), 1'b1, 1'b0, 1'b0}) begin
            bad++; $display("FAIL spaced_end: got cnt=%0d done=%b ovf=%b ext=%b want 10/1/0/0",
                            rx_count, done, overflow, extra_err);
        end
    endtask

    task automatic test_classes();
        logic [31:0] words [6] = '{32'h00000000, 32'h00000001, 32'h7F800000, 32'hFF800000,
                                   32'h7FC00000, 32'h3F800000};
        logic [1:0]  cls   [6] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00};
        clr = 1'b1; cycle(1'b0, 32'd0, 1'b0); clr = 1'b0;
        for (int i = 0; i < 6; i++) cycle(1'b1, words[i], 1'b0);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (out_class !== cls[i] || out_data !== words[i]) begin
                bad++; $display("FAIL class%0d: got %h/%b want %h/%b",
                                i, out_data, out_class, words[i], cls[i]);
            end
            cycle(1'b0, 32'd0, 1'b1);
        end
        // Random words biased toward the special exponents.
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, rand_word(), 1'b1);
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL class_rand%0d: got %h want %h", i, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] first [DEPTH];
        clr = 1'b1; cycle(1'b0, 32'd0, 1'b0); clr = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            logic [31:0] w;
            w = rand_word();
            if (i < DEPTH) first[i] = w;
            cycle(1'b1, w, 1'b0);
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL ovf_fill%0d: got %h want %h", i, dut_vec, model_vec());
            end
        end
        total++;
        if (level !== LW'(DEPTH) || overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_flag: got level=%0d ovf=%b want %0d/1", level, overflow, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            total++;
            if (out_data !== first[i]) begin
                bad++; $display("FAIL ovf_drain%0d: got %h want %h", i, out_data, first[i]);
            end
            cycle(1'b0, 32'd0, 1'b1);
        end
        total++;
        if (dut_vec !== model_vec()) begin
            bad++; $display("FAIL ovf_empty: got %h want %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] tail;
        clr = 1'b1; cycle(1'b0, 32'd0, 1'b0); clr = 1'b0;
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, rand_word(), 1'b0);
        tail = rand_word();
        cycle(1'b1, tail, 1'b1);
        total++;
        if (level !== LW'(DEPTH) || overflow !== 1'b0) begin
            bad++; $display("FAIL full_pp: got level=%0d ovf=%b want %0d/0", level, overflow, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) begin
                total++;
                if (out_data !== tail) begin
                    bad++; $display("FAIL full_pp_tail: got %h want %h", out_data, tail);
                end
            end
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL full_pp_drain%0d: got %h want %h", i, dut_vec, model_vec());
            end
            cycle(1'b0, 32'd0, 1'b1);
        end
    endtask

    task automatic test_extra();
        clr = 1'b1; cycle(1'b0, 32'd0, 1'b0); clr = 1'b0;
        for (int i = 0; i < N + 1; i++) begin
            cycle(1'b1, rand_word(), 1'b0);
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL extra_push%0d: got %h want %h", i, dut_vec, model_vec());
            end
        end
        total++;
        if ({extra_err, rx_count, done} !== {1'b1, CW'(N + 1), 1'b0}) begin
            bad++; $display("FAIL extra_flag: got ext=%b cnt=%0d done=%b want 1/%0d/0",
                            extra_err, rx_count, done, N + 1);
        end
        for (int i = 0; i < N + 1; i++) begin
            cycle(1'b0, 32'd0, 1'b1);
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL extra_drain%0d: got %h want %h", i, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_mid_reset();
        clr = 1'b1; cycle(1'b0, 32'd0, 1'b0); clr = 1'b0;
        for (int i = 0; i < 5; i++) cycle(1'b1, rand_word(), 1'b0);
        rst = 1'b0;
        #1;
        model_clear();
        total++;
        if (out_valid !== 1'b0 || level !== '0 || dut_vec !== model_vec()) begin
            bad++; $display("FAIL async_rst: got %h want %h", dut_vec, model_vec());
        end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) cycle(1'b1, rand_word(), 1'b0);
        total++;
        if (dut_vec !== model_vec()) begin
            bad++; $display("FAIL post_rst: got %h want %h", dut_vec, model_vec());
        end
        clr = 1'b1;
        cycle(1'b1, rand_word(), 1'b1);
        clr = 1'b0;
        total++;
        if (out_valid !== 1'b0 || level !== '0 || dut_vec !== model_vec()) begin
            bad++; $display("FAIL sync_clr: got %h want %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            clr = ($urandom_range(0, 99) == 0);
            cycle(1'($urandom_range(0, 2) != 0), rand_word(), 1'($urandom_range(0, 1)));
            clr = 1'b0;
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL random%0d: got %h want %h", i, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_spaced();
        test_classes();
        test_overflow();
        test_full_push_pop();
        test_extra();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
